hdr_cksum_unit: RTL and testbench

Computes the 16-bit ones'-complement Internet checksum over a byte range of the packet header vector. Responder side of the executor's checksum request interface: it samples a start pulse with field start and length, walks the header one 16-bit word per cycle, and returns the complemented sum with a one-cycle ready pulse. The executor zeroes the destination checksum field before the request and writes `cksum_val_o` back on ready.

---
 rtl/hdr_cksum_unit_pkg.sv | 27 ++
 rtl/hdr_cksum_unit_fetch.sv | 35 +++
 rtl/hdr_cksum_unit.sv | 103 ++++++++++
 tb/tb_hdr_cksum_unit.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/hdr_cksum_unit_pkg.sv
// rtl/hdr_cksum_unit_pkg.sv - shared types and widths for the header checksum unit (CKSUM_DUAL_WORD_EN)
package hdr_cksum_unit_pkg;

    localparam int HDR_MAX_LEN = 64;
    localparam int BYTE_W      = 8;
    localparam int ADDR_W      = 8;
    localparam int DATA_W      = 16;
    localparam int HALF_W      = 16;
    localparam int CKSUM_ACC_W = 32;

`ifdef CKSUM_DUAL_WORD_EN
    localparam int CKSUM_WORDS_PER_CYCLE = 2;
`else
    localparam int CKSUM_WORDS_PER_CYCLE = 1;
`endif

    // Bytes consumed per ACCUM cycle.
    localparam int CKSUM_STEP = 2 * CKSUM_WORDS_PER_CYCLE;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        FOLD,
        DONE
    } cksum_state_e;

endpackage

// File: rtl/hdr_cksum_unit_fetch.sv
// rtl/hdr_cksum_unit_fetch.sv - cksum_word_fetch: zero-filled byte-pair selector (CKSUM_DUAL_WORD_EN)
module cksum_word_fetch
    import hdr_cksum_unit_pkg::*;
#(
    parameter int HDR_LEN = HDR_MAX_LEN
) (
    input  logic [HDR_LEN-1:0][BYTE_W-1:0]                pkt_hdr,
    input  logic [DATA_W-1:0]                             ptr,
    input  logic [DATA_W-1:0]                             rem,
    output logic [CKSUM_WORDS_PER_CYCLE-1:0][HALF_W-1:0]  words
);

    // Bytes past the range length or past the header end read as zero.
    function automatic logic [BYTE_W-1:0] byte_at(
        input logic [HDR_LEN-1:0][BYTE_W-1:0] hdr,
        input logic [DATA_W-1:0]              idx,
        input logic                           en
    );
        byte_at = '0;
        for (int i = 0; i < HDR_LEN; i++) begin
            if (en && (idx == DATA_W'(i))) begin
                byte_at = hdr[i];
            end
        end
    endfunction

    always_comb begin
        words = '0;
        for (int w = 0; w < CKSUM_WORDS_PER_CYCLE; w++) begin
            words[w] = {byte_at(pkt_hdr, ptr + DATA_W'(2 * w),     rem > DATA_W'(2 * w)),
                        byte_at(pkt_hdr, ptr + DATA_W'(2 * w + 1), rem > DATA_W'(2 * w + 1))};
        end
    end

endmodule

// File: rtl/hdr_cksum_unit.sv
// rtl/hdr_cksum_unit.sv - ones'-complement header checksum responder (CKSUM_DUAL_WORD_EN)
module hdr_cksum_unit
    import hdr_cksum_unit_pkg::*;
#(
    parameter int HDR_LEN = HDR_MAX_LEN
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start_i,
    input  logic [HDR_LEN-1:0][BYTE_W-1:0] pkt_hdr_i,
    input  logic [ADDR_W-1:0]              field_start_i,
    input  logic [DATA_W-1:0]              field_len_i,
    output logic [HALF_W-1:0]              cksum_val_o,
    output logic                           cksum_ready_o
);

    cksum_state_e state, state_nxt;

    logic [DATA_W-1:0]      ptr;
    logic [DATA_W-1:0]      rem;
    logic [CKSUM_ACC_W-1:0] acc;
    logic [CKSUM_ACC_W-1:0] word_sum;
    logic [HALF_W:0]        sum17;
    logic [HALF_W-1:0]      fold;

    logic [CKSUM_WORDS_PER_CYCLE-1:0][HALF_W-1:0] words;

    cksum_word_fetch #(.HDR_LEN(HDR_LEN)) u_fetch (
        .pkt_hdr (pkt_hdr_i),
        .ptr     (ptr),
        .rem     (rem),
        .words   (words)
    );

    always_comb begin
        word_sum = '0;
        for (int w = 0; w < CKSUM_WORDS_PER_CYCLE; w++) begin
            word_sum = word_sum + CKSUM_ACC_W'(words[w]);
        end
    end

    // The second add absorbs the end-around carry; it cannot carry again.
    assign sum17 = {1'b0, acc[HALF_W-1:0]} + {1'b0, acc[CKSUM_ACC_W-1:HALF_W]};
    assign fold  = sum17[HALF_W-1:0] + HALF_W'(sum17[HALF_W]);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_nxt = (field_len_i == '0) ? FOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (rem <= DATA_W'(CKSUM_STEP)) begin
                    state_nxt = FOLD;
                end
            end
            FOLD:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr         <= '0;
            rem         <= '0;
            acc         <= '0;
            cksum_val_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        ptr <= DATA_W'(field_start_i);
                        rem <= field_len_i;
                        acc <= '0;
                    end
                end
                ACCUM: begin
                    acc <= acc + word_sum;
                    ptr <= ptr + DATA_W'(CKSUM_STEP);
                    rem <= rem - DATA_W'(CKSUM_STEP);
                end
                FOLD: begin
                    cksum_val_o <= ~fold;
                end
                default: ;
            endcase
        end
    end

    assign cksum_ready_o = (state == DONE);

endmodule

// File: tb/tb_hdr_cksum_unit.sv
// tb/tb_hdr_cksum_unit.sv - directed self-checking bench for hdr_cksum_unit (CKSUM_DUAL_WORD_EN)
module tb_hdr_cksum_unit;

    localparam int HL = 32;
`ifdef CKSUM_DUAL_WORD_EN
    localparam int BPC = 4;
`else
    localparam int BPC = 2;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 start_i = 1'b0;
    logic [HL-1:0][7:0]   pkt_hdr_i = '0;
    logic [7:0]           field_start_i = '0;
    logic [15:0]          field_len_i = '0;
    logic [15:0]          cksum_val_o;
    logic                 cksum_ready_o;

    int total = 0;
    int bad   = 0;

    localparam logic [7:0] IPV4 [20] = '{8'h45, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h40, 8'h00,
                                         8'h40, 8'h11, 8'h00, 8'h00, 8'hc0, 8'ha8, 8'h00, 8'h01,
                                         8'hc0, 8'ha8, 8'h00, 8'hc7};

    hdr_cksum_unit #(.HDR_LEN(HL)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .pkt_hdr_i     (pkt_hdr_i),
        .field_start_i (field_start_i),
        .field_len_i   (field_len_i),
        .cksum_val_o   (cksum_val_o),
        .cksum_ready_o (cksum_ready_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_ipv4();
        pkt_hdr_i = '0;
        for (int i = 0; i < 20; i++) pkt_hdr_i[i] = IPV4[i];
    endtask

    function automatic int exp_lat(input int len);
        return (len + BPC - 1) / BPC + 2;
    endfunction

    // Issue one request, wait for ready, check value, latency and single-cycle pulse.
    task automatic run_req(input string tag, input int fs, input int len, input logic [15:0] exp_val);
        int cnt;
        @(negedge clk);
        start_i       = 1'b1;
        field_start_i = 8'(fs);
        field_len_i   = 16'(len);
        cnt = 0;
        @(posedge clk);
        cnt++;
        @(negedge clk);
        start_i = 1'b0;
        while (!cksum_ready_o && cnt < 64) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
        end
        chk({tag, "_ready"}, 32'(cksum_ready_o), 32'd1);
        chk({tag, "_val"},   32'(cksum_val_o),   32'(exp_val));
        chk({tag, "_lat"},   32'(cnt),           32'(exp_lat(len)));
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(cksum_ready_o), 32'd0);
        chk({tag, "_hold"},  32'(cksum_val_o),   32'(exp_val));
    endtask

    initial begin
        int pulses;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_val",   32'(cksum_val_o),   32'd0);
        chk("reset_ready", 32'(cksum_ready_o), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        load_ipv4();
        run_req("ipv4", 0, 20, 16'hB861);

        pkt_hdr_i = '0;
        pkt_hdr_i[14] = 8'h01; pkt_hdr_i[15] = 8'h02; pkt_hdr_i[16] = 8'h03; pkt_hdr_i[17] = 8'hAA;
        run_req("odd", 14, 3, 16'hFBFD);

        run_req("zero", 5, 0, 16'hFFFF);

        pkt_hdr_i = '0;
        for (int i = 4; i < 8; i++) pkt_hdr_i[i] = 8'hFF;
        run_req("carry", 4, 4, 16'h0000);

        pkt_hdr_i = '0;
        pkt_hdr_i[30] = 8'h12; pkt_hdr_i[31] = 8'h34;
        run_req("oob", 30, 4, 16'hEDCB);

        // Second start during ACCUM must be dropped.
        load_ipv4();
        @(negedge clk);
        start_i = 1'b1; field_start_i = 8'd0; field_len_i = 16'd20;
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        start_i = 1'b1; field_start_i = 8'd14; field_len_i = 16'd3;
        @(negedge clk);
        start_i = 1'b0;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (cksum_ready_o) pulses++;
        end
        chk("busy_pulses", 32'(pulses),      32'd1);
        chk("busy_val",    32'(cksum_val_o), 32'hB861);

        // Asynchronous reset in the middle of ACCUM.
        @(negedge clk);
        start_i = 1'b1; field_start_i = 8'd0; field_len_i = 16'd20;
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst_val",   32'(cksum_val_o),   32'd0);
        chk("rst_ready", 32'(cksum_ready_o), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (cksum_ready_o) chk("rst_idle", 32'(cksum_ready_o), 32'd0);
        end
        run_req("post_rst", 0, 20, 16'hB861);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1);
    end

endmodule
